// File: rtl/sonar_uc_if.sv
// Handshake bundle between the sonar control unit and its datapath.
// master = control unit (drives strobes), slave = datapath side.
interface sonar_uc_if;
  logic       ligar;
  logic       fim_distancia;
  logic       fim_transmissao;
  logic       fim_contador_serial;
  logic       fim_contador_intervalo;
  logic       zera;
  logic       zera_pwm;
  logic       reset_updown;
  logic       conta_updown;
  logic       conta_intervalo;
  logic       medir;
  logic       transmitir;
  logic       conta_serial;
  logic       pronto;
  logic       erro_timeout;
  logic [3:0] db_estado;

  modport master (
    input  ligar, fim_distancia, fim_transmissao, fim_contador_serial,
           fim_contador_intervalo,
    output zera, zera_pwm, reset_updown, conta_updown, conta_intervalo,
           medir, transmitir, conta_serial, pronto, erro_timeout, db_estado
  );

  modport slave (
    output ligar, fim_distancia, fim_transmissao, fim_contador_serial,
           fim_contador_intervalo,
    input  zera, zera_pwm, reset_updown, conta_updown, conta_intervalo,
           medir, transmitir, conta_serial, pronto, erro_timeout, db_estado
  );
endinterface

// File: rtl/sonar_uc.sv
// Sonar control unit: per sweep position waits the interval, measures with a
// watchdog, sends the 8-character frame and steps the servo.
module sonar_uc #(
  parameter int TIMEOUT = 1_500_000,
  parameter int TW      = 21
) (
  input logic       clock,
  input logic       reset,
  sonar_uc_if.master bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA         = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_TX     = 4'd6,
    PROX_CHAR      = 4'd7,
    PROX_POS       = 4'd8,
    ERRO           = 4'd9
  } state_t;

  typedef struct packed {
    logic zera;
    logic zera_pwm;
    logic reset_updown;
    logic conta_updown;
    logic conta_intervalo;
    logic medir;
    logic transmitir;
    logic conta_serial;
    logic pronto;
  } strobes_t;

  state_t          state;
  state_t          state_nxt;
  strobes_t        strobes_q;
  logic            erro_q;
  logic [TW-1:0]   timeout_cnt;
  logic            timeout_hit;

  function automatic state_t next_state(
    input state_t s,
    input logic   ligar,
    input logic   fim_distancia,
    input logic   fim_transmissao,
    input logic   fim_contador_serial,
    input logic   fim_contador_intervalo,
    input logic   hit
  );
    next_state = INICIAL;
    case (s)
      INICIAL:        next_state = ligar ? PREPARA : INICIAL;
      PREPARA:        next_state = ESPERA;
      ESPERA:         next_state = fim_contador_intervalo ? MEDE : ESPERA;
      MEDE:           next_state = AGUARDA_MEDIDA;
      // A measurement landing on the last watchdog cycle still wins.
      AGUARDA_MEDIDA: next_state = fim_distancia ? TRANSMITE :
                                   (hit ? ERRO : AGUARDA_MEDIDA);
      TRANSMITE:      next_state = AGUARDA_TX;
      AGUARDA_TX:     next_state = fim_transmissao ? PROX_CHAR : AGUARDA_TX;
      PROX_CHAR:      next_state = fim_contador_serial ? PROX_POS : TRANSMITE;
      PROX_POS:       next_state = ligar ? ESPERA : INICIAL;
      ERRO:           next_state = PROX_POS;
      default:        next_state = INICIAL;
    endcase
  endfunction

  function automatic strobes_t decode(input state_t s);
    decode = '0;
    case (s)
      PREPARA: begin
        decode.zera         = 1'b1;
        decode.zera_pwm     = 1'b1;
        decode.reset_updown = 1'b1;
      end
      ESPERA:    decode.conta_intervalo = 1'b1;
      MEDE:      decode.medir           = 1'b1;
      TRANSMITE: decode.transmitir      = 1'b1;
      PROX_CHAR: decode.conta_serial    = 1'b1;
      PROX_POS: begin
        decode.conta_updown = 1'b1;
        decode.pronto       = 1'b1;
      end
      AGUARDA_MEDIDA, AGUARDA_TX, ERRO: decode = '0;
      default: begin
        decode.zera     = 1'b1;
        decode.zera_pwm = 1'b1;
      end
    endcase
  endfunction

  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT - 1));

  assign state_nxt = next_state(state, bus.ligar, bus.fim_distancia,
                                bus.fim_transmissao, bus.fim_contador_serial,
                                bus.fim_contador_intervalo, timeout_hit);

  // Strobes are registered from the next state so they line up exactly with
  // the state register, keeping every output free of input-to-output paths.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= INICIAL;
      strobes_q   <= decode(INICIAL);
      erro_q      <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state     <= state_nxt;
      strobes_q <= decode(state_nxt);
      if (state_nxt == ERRO)
        erro_q <= 1'b1;
      else if (state_nxt == PREPARA)
        erro_q <= 1'b0;
      if (state == MEDE)
        timeout_cnt <= '0;
      else if (state == AGUARDA_MEDIDA)
        timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  assign bus.zera            = strobes_q.zera;
  assign bus.zera_pwm        = strobes_q.zera_pwm;
  assign bus.reset_updown    = strobes_q.reset_updown;
  assign bus.conta_updown    = strobes_q.conta_updown;
  assign bus.conta_intervalo = strobes_q.conta_intervalo;
  assign bus.medir           = strobes_q.medir;
  assign bus.transmitir      = strobes_q.transmitir;
  assign bus.conta_serial    = strobes_q.conta_serial;
  assign bus.pronto          = strobes_q.pronto;
  assign bus.erro_timeout    = erro_q;
  assign bus.db_estado       = state;

endmodule

// File: tb/tb_sonar_uc.sv
// Bench for sonar_uc: builds a per-cycle timeline of stimulus and expected
// outputs from phase durations, replays it, and compares every cycle.
module tb_sonar_uc;
  localparam int TIMEOUT = 20;
  localparam int TW      = 5;

  localparam int S_INICIAL = 0, S_PREPARA = 1, S_ESPERA = 2, S_MEDE = 3,
                 S_AGUARDA = 4, S_TRANSMITE = 5, S_AGUARDA_TX = 6,
                 S_PROX_CHAR = 7, S_PROX_POS = 8, S_ERRO = 9;

  typedef struct {
    logic       chk;
    logic       rst_n;
    logic       ligar;
    logic       fd;
    logic       ft;
    logic       fcs;
    logic       fci;
    logic [3:0] st;
    logic       erro;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  sonar_uc_if bus_if ();

  sonar_uc #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  rec_t recs[$];
  logic b_ligar;
  logic b_erro;
  bit   ready = 1'b0;
  int   directed_end;
  int   checks = 0;
  int   errors = 0;

  // Strobe set per state, ordered zera, zera_pwm, reset_updown, conta_updown,
  // conta_intervalo, medir, transmitir, conta_serial, pronto.
  function automatic logic [8:0] outs_of(input logic [3:0] st);
    case (st)
      4'd1:    outs_of = 9'b111000000;
      4'd2:    outs_of = 9'b000010000;
      4'd3:    outs_of = 9'b000001000;
      4'd4:    outs_of = 9'b000000000;
      4'd5:    outs_of = 9'b000000100;
      4'd6:    outs_of = 9'b000000000;
      4'd7:    outs_of = 9'b000000010;
      4'd8:    outs_of = 9'b000100001;
      4'd9:    outs_of = 9'b000000000;
      default: outs_of = 9'b110000000;
    endcase
  endfunction

  task automatic b_push(input int st, input logic fd, input logic ft,
                        input logic fcs, input logic fci);
    rec_t r;
    r.chk   = 1'b1;
    r.rst_n = 1'b1;
    r.ligar = b_ligar;
    r.fd    = fd;
    r.ft    = ft;
    r.fcs   = fcs;
    r.fci   = fci;
    r.st    = 4'(st);
    r.erro  = b_erro;
    recs.push_back(r);
  endtask

  task automatic b_idle_start(input int n);
    b_ligar = 1'b0;
    for (int i = 0; i < n; i++) b_push(S_INICIAL, 0, 0, 0, 0);
    b_ligar = 1'b1;
    b_push(S_INICIAL, 0, 0, 0, 0);
    b_erro = 1'b0;
    b_push(S_PREPARA, 0, 0, 0, 0);
  endtask

  // One sweep position described by its phase lengths.
  task automatic b_position(input int wait_c, input int aguarda_c, input bit loss,
                            input int tx_lo, input int tx_hi, input int drop_char,
                            input int reset_at, output bit need_idle);
    need_idle = 1'b0;
    for (int i = 0; i < wait_c; i++) b_push(S_ESPERA, 0, 0, 0, 0);
    b_push(S_ESPERA, 0, 0, 0, 1);
    b_push(S_MEDE, 0, 0, 0, 0);
    if (loss) begin
      for (int i = 0; i < TIMEOUT; i++) b_push(S_AGUARDA, 0, 0, 0, 0);
      b_erro = 1'b1;
      b_push(S_ERRO, 0, 0, 0, 0);
    end else begin
      for (int i = 0; i < aguarda_c; i++) begin
        if (i == reset_at) begin
          b_push(S_AGUARDA, 0, 0, 0, 0);
          recs[recs.size()-1].rst_n = 1'b0;
          b_erro = 1'b0;
          need_idle = 1'b1;
          return;
        end
        b_push(S_AGUARDA, logic'(i == aguarda_c - 1), 0, 0, 0);
      end
      for (int c = 0; c < 8; c++) begin
        int d;
        d = int'($urandom_range(tx_hi, tx_lo));
        b_push(S_TRANSMITE, 0, 0, logic'(c == 7), 0);
        for (int j = 0; j < d; j++) begin
          if (c == drop_char && j == 0) b_ligar = 1'b0;
          b_push(S_AGUARDA_TX, 0, logic'(j == d - 1), logic'(c == 7), 0);
        end
        b_push(S_PROX_CHAR, 0, 0, logic'(c == 7), 0);
      end
    end
    b_push(S_PROX_POS, 0, 0, 0, 0);
    if (!b_ligar) need_idle = 1'b1;
  endtask

  task automatic applyStimulus(input rec_t r);
    reset                         = r.rst_n;
    bus_if.ligar                  = r.ligar;
    bus_if.fim_distancia          = r.fd;
    bus_if.fim_transmissao        = r.ft;
    bus_if.fim_contador_serial    = r.fcs;
    bus_if.fim_contador_intervalo = r.fci;
  endtask

  task automatic checkOutput(input int k);
    logic [8:0] got_str;
    logic [8:0] exp_str;
    got_str = {bus_if.zera, bus_if.zera_pwm, bus_if.reset_updown,
               bus_if.conta_updown, bus_if.conta_intervalo, bus_if.medir,
               bus_if.transmitir, bus_if.conta_serial, bus_if.pronto};
    exp_str = outs_of(recs[k].st);
    checks++;
    if (got_str !== exp_str || bus_if.db_estado !== recs[k].st ||
        bus_if.erro_timeout !== recs[k].erro) begin
      errors++;
      $display("[TB] FAIL cycle_%0d: got st=%0d str=%b erro=%b, expected st=%0d str=%b erro=%b",
               k, bus_if.db_estado, got_str, bus_if.erro_timeout,
               recs[k].st, exp_str, recs[k].erro);
    end
  endtask

  task automatic checkLiteral(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Build the timeline, then drive it one record per cycle.
  initial begin
    rec_t r0;
    bit   idle;
    b_ligar = 1'b1;
    b_erro  = 1'b0;
    r0.chk = 1'b0; r0.rst_n = 1'b0; r0.ligar = 1'b1; r0.fd = 1'b0; r0.ft = 1'b0;
    r0.fcs = 1'b0; r0.fci = 1'b0; r0.st = 4'd0; r0.erro = 1'b0;
    recs.push_back(r0);
    b_push(S_INICIAL, 0, 0, 0, 0);
    recs[recs.size()-1].rst_n = 1'b0;
    b_push(S_INICIAL, 0, 0, 0, 0);
    recs[recs.size()-1].rst_n = 1'b0;
    b_push(S_INICIAL, 0, 0, 0, 0);
    b_push(S_PREPARA, 0, 0, 0, 0);
    b_position(2, 5, 0, 3, 3, -1, -1, idle);
    b_position(1, 0, 1, 3, 3, -1, -1, idle);
    b_position(0, 3, 0, 3, 3, 2, -1, idle);
    b_idle_start(3);
    b_position(1, TIMEOUT, 0, 3, 3, -1, -1, idle);
    b_position(0, 10, 0, 3, 3, -1, 7, idle);
    b_idle_start(2);
    b_position(0, 0, 1, 3, 3, -1, -1, idle);
    directed_end = recs.size();
    for (int p = 0; p < 25; p++) begin
      int  ag;
      bit  loss;
      int  drop;
      int  rat;
      ag   = int'($urandom_range(TIMEOUT, 1));
      loss = ($urandom_range(3, 0) == 0);
      drop = ($urandom_range(5, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      rat  = (!loss && $urandom_range(7, 0) == 0) ? int'($urandom_range(ag - 1, 0)) : -1;
      b_position(int'($urandom_range(4, 0)), ag, loss, 1, 4, drop, rat, idle);
      if (idle) b_idle_start(int'($urandom_range(3, 0)));
    end
    ready = 1'b1;
    applyStimulus(recs[0]);
    for (int k = 1; k < recs.size(); k++) begin
      @(posedge clock);
      #1 applyStimulus(recs[k]);
    end
  end

  // Compare process: every cycle against the timeline, plus hand-counted
  // totals over the directed part.
  initial begin
    int n_pronto = 0, n_medir = 0, n_tx = 0, n_serial = 0, n_rupd = 0, n_updown = 0;
    int last_mede = -1;
    int erro_gap = -1;
    wait (ready);
    for (int k = 1; k < recs.size(); k++) begin
      @(negedge clock);
      checkOutput(k);
      if (k < directed_end) begin
        n_pronto += int'(bus_if.pronto === 1'b1);
        n_medir  += int'(bus_if.medir === 1'b1);
        n_tx     += int'(bus_if.transmitir === 1'b1);
        n_serial += int'(bus_if.conta_serial === 1'b1);
        n_rupd   += int'(bus_if.reset_updown === 1'b1);
        n_updown += int'(bus_if.conta_updown === 1'b1);
        if (bus_if.db_estado === 4'd3) last_mede = k;
        if (bus_if.db_estado === 4'd9 && erro_gap < 0) erro_gap = k - last_mede;
      end
      if (k == directed_end - 1) begin
        checkLiteral("pronto_count", n_pronto, 5);
        checkLiteral("medir_count", n_medir, 6);
        checkLiteral("transmitir_count", n_tx, 24);
        checkLiteral("conta_serial_count", n_serial, 24);
        checkLiteral("reset_updown_count", n_rupd, 3);
        checkLiteral("conta_updown_count", n_updown, 5);
        checkLiteral("mede_to_erro_gap", erro_gap, 21);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/sonar_uc.md
Name: sonar_uc

Overview:
- Control unit for the sonar datapath (ultrasonic interface, servo PWM, up/down position counter, interval counter, 8-character serial frame counter, 7O1 transmitter).
- Per sweep position it sequences:
  1. Wait for the interval timer.
  2. Trigger one distance measurement, with a watchdog timeout.
  3. Transmit the 8-character frame "ccc,ddd#", one character at a time.
  4. Step the servo to the next position.
- Sits beside the datapath in the sonar top level; all datapath control strobes come from this block.

Parameters:
- TIMEOUT, 1_500_000, clock cycles allowed in AGUARDA_MEDIDA before declaring echo loss (30 ms @ 50 MHz); minimum 2.
- TW, 21, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ligar  in  1  enable sweep; level-sensitive.
- fim_distancia  in  1  measurement-done pulse from the datapath.
- fim_transmissao  in  1  character-transmitted pulse from the datapath.
- fim_contador_serial  in  1  high while the serial character index = 7.
- fim_contador_intervalo  in  1  interval-elapsed pulse.
- zera  out  1  active-high datapath reset.
- zera_pwm  out  1  servo PWM reset (servo idle).
- reset_updown  out  1  synchronous clear of the position counter.
- conta_updown  out  1  one-cycle position-step strobe.
- conta_intervalo  out  1  interval-counter enable.
- medir  out  1  one-cycle measure request.
- transmitir  out  1  one-cycle transmit start.
- conta_serial  out  1  one-cycle character-index advance.
- pronto  out  1  one-cycle pulse per completed position (frame sent or error).
- erro_timeout  out  1  sticky echo-loss flag.
- db_estado  out  4  current state encoding.

Behaviour:
- Moore FSM, registered state; all strobes decode combinationally from state (no input-to-output paths).
- State encodings (db_estado):
  - INICIAL 0: zera=1, zera_pwm=1. If ligar=1 go to PREPARA, else stay.
  - PREPARA 1: zera=1, zera_pwm=1, reset_updown=1. Clears erro_timeout. Go to ESPERA.
  - ESPERA 2: conta_intervalo=1. If fim_contador_intervalo=1 go to MEDE, else stay.
  - MEDE 3: medir=1. Timeout counter loaded to 0. Go to AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA 4: timeout counter increments.
    - fim_distancia=1: go to TRANSMITE. Has priority over the timeout.
    - Otherwise, counter = TIMEOUT-1: go to ERRO.
    - Otherwise stay.
  - TRANSMITE 5: transmitir=1. Go to AGUARDA_TX.
  - AGUARDA_TX 6: if fim_transmissao=1 go to PROX_CHAR, else stay.
  - PROX_CHAR 7: conta_serial=1.
    - If fim_contador_serial=1 (last character just sent), go to PROX_POS; the index wraps to 0.
    - Otherwise go to TRANSMITE.
  - PROX_POS 8: conta_updown=1, pronto=1.
    - If ligar=1 go to ESPERA, else go to INICIAL.
  - ERRO 9: erro_timeout set to 1. Go to PROX_POS; no frame is transmitted for that position.
  - Encodings 10–15: go to INICIAL next cycle; outputs as INICIAL.
- zera_pwm=0 in every state other than INICIAL/PREPARA; the servo holds its position throughout a sweep.
- ligar is sampled only in INICIAL and PROX_POS. Deasserting ligar mid-position completes the current frame, then stops.
- Frame timing:
  - Exactly 8 transmitir pulses per non-error position.
  - 8 conta_serial pulses per non-error position, so the serial index always returns to 0.
- Latency:
  - ligar to first conta_intervalo: 2 cycles (INICIAL, PREPARA).
  - fim_distancia to transmitir: 1 cycle.
- Timeout counter: TW bits, unsigned; reset and MEDE load it to 0; it never wraps, because the transition fires at TIMEOUT-1.
- reset=0 at any clock edge, including mid-frame:
  - Next state is INICIAL and erro_timeout=0.
  - All strobes are 0 except zera=1 and zera_pwm=1.
  - The timeout counter is 0.
- erro_timeout persists across positions until PREPARA or reset.

Test Plan:
- Reset with ligar=1, reset=0 for 3 cycles, then 1 -> db_estado=0 while reset low; zera=1, zera_pwm=1; then 1 then 2 on the following edges; reset_updown high exactly 1 cycle.
- Nominal position (TIMEOUT=20): fim_contador_intervalo pulse, fim_distancia 5 cycles after medir, each fim_transmissao 3 cycles after transmitir, fim_contador_serial modelled from a 0–7 counter -> medir=1 once; transmitir=8 pulses; conta_serial=8 pulses; then conta_updown=1 and pronto=1 in the same cycle; erro_timeout=0.
- Echo loss (TIMEOUT=20), fim_distancia never asserted -> ERRO reached exactly 20 cycles after leaving MEDE; zero transmitir pulses; erro_timeout=1 and stays 1 through the next position; cleared after ligar cycles 0 then 1 through PREPARA.
- fim_distancia and the timeout boundary in the same cycle (counter=19) -> next state TRANSMITE, erro_timeout=0.
- ligar dropped during AGUARDA_TX of character 3 -> remaining 5 characters still sent; PROX_POS then INICIAL; zera_pwm=1 afterwards.
- reset=0 asserted in AGUARDA_MEDIDA -> next state INICIAL; no medir/transmitir strobes; timeout counter restarts from 0 on the next MEDE.
